// File: rtl/spi_ram_master.sv
// Command-word serialiser for the SPI slave + RAM subsystem; captures read-data replies from MISO.
// Define SPI_RAM_MASTER_STATS_EN to add saturating frame_cnt / rd_cnt outputs.
module spi_ram_master #(
  parameter int FRAME_W    = 10,
  parameter int RD_W       = 8,
  parameter int TURNAROUND = 2
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FRAME_W-1:0] cmd_data,
  output logic [RD_W-1:0]    rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
`ifdef SPI_RAM_MASTER_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        rd_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP} state_e;

  state_e             state_q;
  logic [FRAME_W-1:0] shift_q;
  logic [RD_W-2:0]    cap_q;
  logic [RD_W-1:0]    rd_data_q;
  logic [3:0]         cnt_q;
  logic [2:0]         ta_q;
  logic               rd_cmd_q, ss_n_q, mosi_q, ready_q, busy_q, rd_valid_q;
  logic               last_bit, last_smp;

  assign last_bit = (state_q == SEND) && (cnt_q == 4'(FRAME_W-1));
  assign last_smp = (state_q == RECV) && (cnt_q == 4'(RD_W-1));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      ta_q       <= '0;
      rd_cmd_q   <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (cmd_valid) begin
          // MSB goes out right away; the rest waits pre-shifted
          mosi_q   <= cmd_data[FRAME_W-1];
          shift_q  <= cmd_data << 1;
          rd_cmd_q <= &cmd_data[FRAME_W-1:FRAME_W-2];
          cnt_q    <= '0;
          ss_n_q   <= 1'b0;
          ready_q  <= 1'b0;
          busy_q   <= 1'b1;
          state_q  <= SEND;
        end
        SEND: if (last_bit) begin
          mosi_q <= 1'b0;
          cnt_q  <= '0;
          if (rd_cmd_q) begin
            ta_q    <= '0;
            state_q <= WAIT;
          end else begin
            ss_n_q  <= 1'b1;
            state_q <= GAP;
          end
        end else begin
          mosi_q  <= shift_q[FRAME_W-1];
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + 4'd1;
        end
        WAIT: if (ta_q == 3'(TURNAROUND-1)) begin
          cnt_q   <= '0;
          state_q <= RECV;
        end else begin
          ta_q <= ta_q + 3'd1;
        end
        RECV: begin
          cap_q <= {cap_q[RD_W-3:0], MISO};
          if (last_smp) begin
            rd_data_q  <= {cap_q, MISO};
            rd_valid_q <= 1'b1;
            ss_n_q     <= 1'b1;
            state_q    <= GAP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        GAP: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

`ifdef SPI_RAM_MASTER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, rd_cnt_q, rd_cnt_d;

  assign frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
  assign rd_cnt_d    = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      rd_cnt_q    <= '0;
    end else begin
      if (last_bit) frame_cnt_q <= frame_cnt_d;
      if (last_smp) rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign rd_cnt    = rd_cnt_q;
`endif

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: behavioural slave+RAM on the serial side, scoreboard of expected frames/replies.
module tb_spi_ram_master;
  localparam int TA = 2;

  logic       CLK = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0, MISO = 1'b0;
  logic [9:0] cmd_data = '0;
  logic       cmd_ready, rd_valid, busy, SS_n, MOSI;
  logic [7:0] rd_data;
`ifdef SPI_RAM_MASTER_STATS_EN
  logic [15:0] frame_cnt, rd_cnt;
`endif

  spi_ram_master #(.FRAME_W(10), .RD_W(8), .TURNAROUND(TA)) dut (
    .CLK(CLK), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
`ifdef SPI_RAM_MASTER_STATS_EN
    , .frame_cnt(frame_cnt), .rd_cnt(rd_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [9:0] cmd; logic [7:0] exp; } vec_t;
  typedef struct { logic [7:0] d; int unsigned hs; } rd_exp_t;

  logic [9:0]  exp_frames[$];
  rd_exp_t     exp_rd[$];
  int          total = 0, bad = 0;
  bit          mon_en = 1'b1, b2b = 1'b0;
  int unsigned hs_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Slave + RAM: shifts in MOSI while selected, answers read-data after the turnaround
  task automatic slave_model();
    logic [7:0] mem [256];
    logic [7:0] addr = '0, b;
    logic [9:0] w = '0;
    logic       ss, mo, nxt;
    int         sc = 0, p = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(posedge CLK);
      ss = SS_n;
      mo = MOSI;
      nxt = 1'($urandom);
      if (ss) begin
        sc = 0;
        p  = 0;
      end else if (sc < 10) begin
        w = {w[8:0], mo};
        sc++;
        if (sc == 10) begin
          case (w[9:8])
            2'b00, 2'b10: addr = w[7:0];
            2'b01:        mem[addr] = w[7:0];
            default: ;
          endcase
        end
      end else begin
        if (w[9:8] == 2'b11 && p >= TA-1 && p < TA-1+8) begin
          b   = mem[addr];
          nxt = b[7-(p-(TA-1))];
        end
        p++;
      end
      #1 MISO = nxt;
    end
  endtask

  task automatic monitor();
    int         lo = 0, hi = 100, mz = 0;
    logic [9:0] fr = '0, e;
    rd_exp_t    r;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        lo = 0;
        hi = 100;
        continue;
      end
      if (!SS_n) begin
        if (lo == 0) begin
          chk("gap_min2", 32'(hi >= 2), 1);
          if (b2b) chk("gap_b2b", hi, 2);
          mz = 0;
        end
        if (lo < 10) fr = {fr[8:0], MOSI};
        else if (MOSI !== 1'b0) mz++;
        lo++;
        hi = 0;
      end else begin
        if (lo > 0) begin
          if (exp_frames.size() == 0) fail_now("unexpected_frame");
          else begin
            e = exp_frames.pop_front();
            chk("frame_word", fr, e);
            chk("frame_len", lo, (e[9:8] == 2'b11) ? 20 : 10);
            chk("mosi_quiet", mz, 0);
          end
        end
        lo = 0;
        hi++;
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) fail_now("unexpected_rd_valid");
        else begin
          r = exp_rd.pop_front();
          chk("rd_data", rd_data, r.d);
          chk("rd_latency", cyc - r.hs, 21);
        end
      end
    end
  endtask

  task automatic issue(input logic [9:0] w, input bit keep, input logic [7:0] erd);
    int n;
    rd_exp_t r;
    cmd_data  = w;
    cmd_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(posedge CLK);
      if (cmd_ready) break;
    end
    if (n == 200) fail_now("handshake_timeout");
    else begin
      hs_cyc = cyc;
      exp_frames.push_back(w);
      if (w[9:8] == 2'b11) begin
        r.d  = erd;
        r.hs = cyc;
        exp_rd.push_back(r);
      end
    end
    #1;
    if (!keep) begin
      cmd_valid = 1'b0;
      cmd_data  = 10'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 500; n++) begin
      @(negedge CLK);
      if (!busy && exp_frames.size() == 0 && exp_rd.size() == 0) break;
    end
    if (n == 500) fail_now("idle_timeout");
  endtask

  initial begin
    vec_t        vt [10];
    int          n, cnt;
    int unsigned hs;

    vt[0] = '{10'h010, 8'h00};  // wr addr 0x10
    vt[1] = '{10'h13C, 8'h00};  // wr data 0x3C
    vt[2] = '{10'h210, 8'h00};  // rd addr 0x10
    vt[3] = '{10'h300, 8'h3C};  // rd data
    vt[4] = '{10'h020, 8'h00};
    vt[5] = '{10'h1C3, 8'h00};
    vt[6] = '{10'h220, 8'h00};
    vt[7] = '{10'h3FF, 8'hC3};  // payload of rd data is don't-care
    vt[8] = '{10'h210, 8'h00};
    vt[9] = '{10'h355, 8'h3C};

    fork
      slave_model();
      monitor();
    join_none

    #1 rst_n = 1'b0;
    #11;
    chk("rst_outputs", {SS_n, MOSI, cmd_ready, busy, rd_valid}, 5'b10100);
    chk("rst_rd_data", rd_data, 8'h00);
    @(negedge CLK) rst_n = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      chk("idle_outputs", {SS_n, MOSI, cmd_ready, busy, rd_valid}, 5'b10100);
    end

    // single write-address frame, 0xA5
    issue(10'h0A5, 1'b0, 8'h00);
    hs = hs_cyc;
    for (n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (cmd_ready) break;
    end
    chk("ready_latency", cyc - hs, 12);
    wait_idle();

    for (int i = 0; i < 10; i++) issue(vt[i].cmd, 1'b0, vt[i].exp);
    wait_idle();

    // cmd_valid held high across three writes
    issue(10'h030, 1'b1, 8'h00);
    issue(10'h15A, 1'b1, 8'h00);
    b2b = 1'b1;
    issue(10'h031, 1'b0, 8'h00);
    wait_idle();
    b2b = 1'b0;

    // reset during bit 5 of a read-data frame
    mon_en = 1'b0;
    issue(10'h3A5, 1'b0, 8'h00);
    repeat (5) @(posedge CLK);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ss_n", SS_n, 1'b1);
    chk("midrst_rd", {rd_valid, rd_data}, 9'h000);
    @(negedge CLK);
    @(negedge CLK) rst_n = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(negedge CLK);
      if (rd_valid) cnt++;
    end
    chk("midrst_no_rd_valid", cnt, 0);
    exp_frames.delete();
    exp_rd.delete();
    mon_en = 1'b1;
    issue(10'h210, 1'b0, 8'h00);
    issue(10'h300, 1'b0, 8'h3C);
    wait_idle();

`ifdef SPI_RAM_MASTER_STATS_EN
    @(negedge CLK) rst_n = 1'b0;
    @(negedge CLK) rst_n = 1'b1;
    chk("stats_rst", {frame_cnt, rd_cnt}, 32'h0);
    issue(10'h010, 1'b0, 8'h00);
    issue(10'h13C, 1'b0, 8'h00);
    issue(10'h010, 1'b0, 8'h00);
    issue(10'h300, 1'b0, 8'h3C);
    issue(10'h300, 1'b0, 8'h3C);
    wait_idle();
    chk("frame_cnt", frame_cnt, 16'd5);
    chk("rd_cnt", rd_cnt, 16'd2);
    @(negedge CLK);
    force dut.frame_cnt_q = 16'hFFFE;
    #1 release dut.frame_cnt_q;
    for (int i = 0; i < 3; i++) issue(10'h011, 1'b0, 8'h00);
    wait_idle();
    chk("frame_cnt_sat", frame_cnt, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
